// File: rtl/ssrv_tcm_pkg.sv
// ssrv_tcm_pkg: shared width encodings, latency limit and response tag for the ssrv TCM.
package ssrv_tcm_pkg;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [1:0] W_RSVD = 2'd3;
  localparam int LAT_MAX = 4;
  typedef struct packed {
    logic       err;
    logic [1:0] width;
    logic [1:0] off;
  } tag_t;
  function automatic logic [31:0] load_align(input logic [31:0] w, input logic [1:0] width, input logic [1:0] off);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return width == W_BYTE ? {24'd0, s[7:0]} : width == W_HALF ? {16'd0, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/ssrv_tcm_ram.sv
// ssrv_tcm_ram: true dual-port RAM; port A read-only, port B byte-enabled read-before-write.
module ssrv_tcm_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic [AW-1:0]     a_addr,
  output logic [XLEN-1:0]   a_rdata,
  input  logic              b_en,
  input  logic [XLEN/8-1:0] b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [XLEN-1:0]   b_wdata,
  output logic [XLEN-1:0]   b_rdata
);
  logic [XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (a_en) a_rdata <= mem[a_addr];
  always_ff @(posedge clk)
    if (b_en) begin
      b_rdata <= mem[b_addr];
      for (int i = 0; i < XLEN/8; i++)
        if (b_we[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
    end
endmodule

// File: rtl/ssrv_tcm.sv
// ssrv_tcm: windowed fetch + load/store TCM with error responses and fixed per-port latency.
module ssrv_tcm
  import ssrv_tcm_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ILAT      = 1,
  parameter int          DLAT      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_resp,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_err,
  input  logic            dmem_req,
  input  logic            dmem_cmd,
  input  logic [1:0]      dmem_width,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_resp,
  output logic            dmem_err
);
  localparam int AW = $clog2(DEPTH);
  if (ILAT < 1 || ILAT > LAT_MAX || DLAT < 1 || DLAT > LAT_MAX) begin : g_bad_lat
    $error("ssrv_tcm: latency out of range");
  end
  typedef struct packed {
    logic v;
    logic st;
    tag_t t;
  } dstage_t;
  logic [XLEN-1:0] irel, drel, a_rdata, b_rdata, i_word, d_word, wd;
  logic i_in, d_in, d_err, a_en, b_en;
  logic [3:0] be;
  logic [ILAT-1:0] iv, ie;
  dstage_t [DLAT-1:0] dp;
  assign irel = imem_addr - BASE_ADDR;
  assign drel = dmem_addr - BASE_ADDR;
  assign i_in = (irel >> (AW + 2)) == '0;
  assign d_in = (drel >> (AW + 2)) == '0;
  assign d_err = ~d_in | dmem_width == W_RSVD | (dmem_width == W_HALF & dmem_addr[0])
               | (dmem_width == W_WORD & dmem_addr[1:0] != 2'b00);
  assign a_en = imem_req & i_in;
  assign b_en = dmem_req & ~d_err;
  assign be = dmem_width == W_WORD ? 4'b1111 : dmem_width == W_HALF ? 4'b0011 << {dmem_addr[1], 1'b0}
            : 4'b0001 << dmem_addr[1:0];
  assign wd = dmem_width == W_WORD ? dmem_wdata : dmem_width == W_HALF ? {2{dmem_wdata[15:0]}}
            : {4{dmem_wdata[7:0]}};
  ssrv_tcm_ram #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .a_en    (a_en),
    .a_addr  (irel[AW+1:2]),
    .a_rdata (a_rdata),
    .b_en    (b_en),
    .b_we    ({4{b_en & dmem_cmd}} & be),
    .b_addr  (drel[AW+1:2]),
    .b_wdata (wd),
    .b_rdata (b_rdata)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      iv <= '0;
      ie <= '0;
      dp <= '0;
    end else begin
      iv[0] <= imem_req;
      ie[0] <= imem_req & ~i_in;
      dp[0] <= {dmem_req, dmem_cmd, dmem_req & d_err, dmem_width, dmem_addr[1:0]};
      for (int k = 1; k < ILAT; k++) begin
        iv[k] <= iv[k-1];
        ie[k] <= ie[k-1];
      end
      for (int k = 1; k < DLAT; k++) dp[k] <= dp[k-1];
    end
  // RAM read data is already one cycle late; extra stages only for LAT > 1
  if (ILAT == 1) begin : g_i1
    assign i_word = a_rdata;
  end else begin : g_in
    logic [ILAT-2:0][XLEN-1:0] q;
    always_ff @(posedge clk) begin
      q[0] <= a_rdata;
      for (int k = 1; k < ILAT - 1; k++) q[k] <= q[k-1];
    end
    assign i_word = q[ILAT-2];
  end
  if (DLAT == 1) begin : g_d1
    assign d_word = b_rdata;
  end else begin : g_dn
    logic [DLAT-2:0][XLEN-1:0] q;
    always_ff @(posedge clk) begin
      q[0] <= b_rdata;
      for (int k = 1; k < DLAT - 1; k++) q[k] <= q[k-1];
    end
    assign d_word = q[DLAT-2];
  end
  assign imem_resp  = iv[ILAT-1];
  assign imem_err   = ie[ILAT-1];
  assign imem_rdata = iv[ILAT-1] & ~ie[ILAT-1] ? i_word : '0;
  assign dmem_resp  = dp[DLAT-1].v;
  assign dmem_err   = dp[DLAT-1].t.err;
  assign dmem_rdata = dp[DLAT-1].v & ~dp[DLAT-1].t.err & ~dp[DLAT-1].st
                    ? load_align(d_word, dp[DLAT-1].t.width, dp[DLAT-1].t.off) : '0;
endmodule
